if_fetch_unit: RTL

//  Instruction-fetch front end that produces the PC+4 / instruction pair written into the
//  IF->ID pipeline register. Owns the PC and runs a req/ready handshake to a variable-latency

---
 rtl/if_fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC and runs a req/ready handshake to a
// variable-latency instruction memory, honouring freeze and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {FETCH, READY, SQUASH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] stale_q, stale_d;
  logic        consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    stale_d     = stale_q;
    imem_req    = ~rst & (state_q != READY);
    // While squashing, the memory still owns the old request, so its address must not move.
    imem_addr   = (state_q == SQUASH) ? stale_q : pc_q;
    if_valid    = ~rst & ~branch_taken &
                  (((state_q == FETCH) & imem_ready) | (state_q == READY));
    instruction = (state_q == READY) ? buf_q : imem_rdata;
    PC          = pc_q + 32'd4;
    fetch_stall = ~if_valid;
    consume     = if_valid & ~freeze;

    if (branch_taken) begin
      pc_d = {branch_addr[31:2], 2'b00};
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            state_d = FETCH;
          end else begin
            state_d = SQUASH;
            stale_d = pc_q;
          end
        end
        READY:   state_d = FETCH;
        SQUASH:  state_d = imem_ready ? FETCH : SQUASH;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (consume) begin
              pc_d = pc_q + 32'd4;
            end else begin
              buf_d   = imem_rdata;
              state_d = READY;
            end
          end
        end
        READY: begin
          if (consume) begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end
        SQUASH: begin
          if (imem_ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
